cond_eval_unit: RTL
===================

COND_EVAL_UNIT -- requirements
Module: cond_eval_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: pend_set  in  1  a flag-writing ALU op issued this cycle.
REQ-004 SHALL have ports: flag_wr  in  1  ALU flags valid for PSR write this cycle.
REQ-005 SHALL have ports: flag_in  in  4  {N,Z,C,V} from ALU; C is carry for ADD, borrow (A<B) for SUB.
REQ-006 SHALL have ports: q_valid  in  1  condition query offered.
REQ-007 SHALL have ports: q_cond  in  4  condition code of query.
REQ-008 SHALL have ports: q_ready  out  1  query accepted when q_valid & q_ready.
REQ-009 SHALL have ports: r_valid  out  1  result available.
REQ-010 SHALL have ports: r_ready  in  1  result consumed when r_valid & r_ready.
REQ-011 SHALL have ports: r_taken  out  1  condition evaluated true.
REQ-012 SHALL have ports: psr  out  4  current {N,Z,C,V}.
REQ-013 SHALL have ports: pend_cnt  out  2  outstanding flag writers.
REQ-014 SHALL have ports: ovf_err  out  1  sticky pending-counter overflow.

Function
REQ-015 SHALL write psr <= flag_in on every clk edge with flag_wr=1, regardless of pend_cnt.
REQ-016 SHALL update pend_cnt: +1 on pend_set only, -1 on flag_wr only, unchanged on both or neither.
REQ-017 SHALL saturate pend_cnt at 3: pend_set at 3 without flag_wr ignored, ovf_err set until reset.
REQ-018 SHALL floor pend_cnt at 0: flag_wr at 0 still writes psr, count stays 0.
REQ-019 SHALL assert q_ready only when output slot free, or slot full and r_ready=1, AND hazard clear.
REQ-020 SHALL treat hazard clear as: pend_cnt==0 and no pend_set, or pend_cnt==1 with flag_wr and no pend_set (bypass).
REQ-021 SHALL evaluate an accepted query against flag_in when bypassing, else against psr.
REQ-022 SHALL decode codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
REQ-023 SHALL decode codes: 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V.
REQ-024 SHALL decode codes: C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-025 SHALL have 1-cycle latency: r_valid and r_taken register on the edge accepting the query.
REQ-026 SHALL run a two-state output FSM: EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain with accept.
REQ-027 SHALL hold r_taken stable while r_valid=1 and r_ready=0.
REQ-028 SHALL sustain one query per cycle when r_ready=1 and hazard clear.

Reset
REQ-029 SHALL on reset force psr=0, pend_cnt=0, ovf_err=0, r_valid=0, r_taken=0, FSM=EMPTY immediately.
REQ-030 SHALL discard any in-flight result on reset mid-operation; no result is replayed.
REQ-031 SHALL drive q_ready=0 while reset is asserted.

Structure
REQ-032 SHALL take condition-code encodings and flag bit positions (N=3,Z=2,C=1,V=0) from the shared CPU package used with the ALU.
REQ-033 SHALL place the 16-way decode in combinational sub-module cond_decode (inputs flags, cond; output taken).
REQ-034 SHALL contain all state (psr, counter, FSM, result register) in cond_eval_unit only.

Verification
REQ-035 SHALL cover: flag_wr, flag_in=0100; next cycle query cond=0 -> r_valid next cycle, r_taken=1; cond=1 -> 0.
REQ-036 SHALL cover: pend_set once, query cond=0 offered -> q_ready=0 until the flag_wr cycle; flag_in=0000 bypassed -> r_taken=0.
REQ-037 SHALL cover: pend_set 4 cycles, no flag_wr -> pend_cnt=3, ovf_err=1 sticky; 3 flag_wr -> pend_cnt=0, ovf_err=1.
REQ-038 SHALL cover: psr=1001 (N=1,V=1); codes A,B,C,D -> 1,0,1,0; E -> 1; F -> 0.
REQ-039 SHALL cover: r_ready=0 for 3 cycles with r_valid=1 -> r_taken stable, q_ready=0; r_ready=1 with query -> back-to-back results.
REQ-040 SHALL cover: reset asserted while r_valid=1, pend_cnt=2 -> all outputs 0 same cycle, no result after release.

Source files
------------

// File: rtl/cond_eval_unit_pkg.sv
// Shared CPU definitions: condition-code encodings and PSR flag bit positions.
// Used by both the ALU and the condition evaluation logic.
package cond_eval_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

endpackage

// File: rtl/cond_eval_unit_if.sv
// Flag-write, query and result signals between the pipeline and the condition unit.
// The unit is the slave; the issuing pipeline (or bench) is the master.
interface cond_eval_unit_if;

  logic       pend_set;
  logic       flag_wr;
  logic [3:0] flag_in;
  logic       q_valid;
  logic [3:0] q_cond;
  logic       q_ready;
  logic       r_valid;
  logic       r_ready;
  logic       r_taken;
  logic [3:0] psr;
  logic [1:0] pend_cnt;
  logic       ovf_err;

  modport slave (
    input  pend_set, flag_wr, flag_in, q_valid, q_cond, r_ready,
    output q_ready, r_valid, r_taken, psr, pend_cnt, ovf_err
  );

  modport master (
    output pend_set, flag_wr, flag_in, q_valid, q_cond, r_ready,
    input  q_ready, r_valid, r_taken, psr, pend_cnt, ovf_err
  );

endinterface

// File: rtl/cond_eval_unit_cond_decode.sv
// Purely combinational 16-way condition-code decode against {N,Z,C,V}.
// Zero latency; no flow control.
module cond_decode
  import cond_eval_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_eval_unit.sv
// Holds the PSR, counts in-flight flag writers and answers condition queries with a
// 1-cycle registered result; queries stall on a flag hazard or a full, unconsumed result slot.
module cond_eval_unit
  import cond_eval_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  cond_eval_unit_if.slave io
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [3:0] psr_q, psr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic [0:0] state_q, state_d;
  logic       taken_q, taken_d;

  logic       slot_free;
  logic       hazard_clr;
  logic       bypass;
  logic       q_ready;
  logic       accept;
  logic       drain;
  logic [3:0] eval_flags;
  logic       eval_taken;

  // A single outstanding writer whose flags arrive this cycle can be forwarded.
  always_comb begin
    bypass     = (cnt_q == 2'd1) && io.flag_wr && !io.pend_set;
    hazard_clr = !io.pend_set && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && io.flag_wr));
    slot_free  = (state_q == S_EMPTY) || io.r_ready;
    q_ready    = !reset && slot_free && hazard_clr;
    accept     = io.q_valid && q_ready;
    drain      = (state_q == S_FULL) && io.r_ready;
    eval_flags = bypass ? io.flag_in : psr_q;
  end

  cond_decode u_decode (
    .flags (eval_flags),
    .cond  (io.q_cond),
    .taken (eval_taken)
  );

  always_comb begin
    psr_d = io.flag_wr ? io.flag_in : psr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (io.pend_set && !io.flag_wr) begin
      if (cnt_q == 2'd3) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else if (io.flag_wr && !io.pend_set && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    if (accept) begin
      state_d = S_FULL;
      taken_d = eval_taken;
    end else if (drain) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psr_q   <= 4'd0;
      cnt_q   <= 2'd0;
      ovf_q   <= 1'b0;
      state_q <= S_EMPTY;
      taken_q <= 1'b0;
    end else begin
      psr_q   <= psr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  assign io.q_ready  = q_ready;
  assign io.r_valid  = (state_q == S_FULL);
  assign io.r_taken  = taken_q;
  assign io.psr      = psr_q;
  assign io.pend_cnt = cnt_q;
  assign io.ovf_err  = ovf_q;

endmodule
